// File: rtl/apb_drp_completer_if.sv
// APB bus bundle for apb_drp_completer: requester drives master, completer uses slave.
interface apb_drp_completer_if #(
    parameter int ADDR_WIDTH = 10
);
    logic                  psel;
    logic                  penable;
    logic                  pwrite;
    logic [ADDR_WIDTH-1:0] paddr;
    logic [31:0]           pwdata;
    logic                  pready;
    logic [31:0]           prdata;
    logic                  pslverr;

    modport master (
        output psel, penable, pwrite, paddr, pwdata,
        input  pready, prdata, pslverr
    );

    modport slave (
        input  psel, penable, pwrite, paddr, pwdata,
        output pready, prdata, pslverr
    );
endinterface

// File: rtl/apb_drp_completer.sv
// APB completer serializing one Xilinx DRP op per transfer.
// Optional DRP timeout (missing drp_rdy -> PSLVERR) enabled by defining APB_DRP_COMPLETER_TIMEOUT_EN.
module apb_drp_completer #(
    parameter int ADDR_WIDTH     = 10,
    parameter int DRP_ADDR_WIDTH = 9,
    parameter int TIMEOUT        = 64
) (
    input  logic                      clk,
    input  logic                      rst,
    apb_drp_completer_if.slave        apb,
    output logic                      drp_en,
    output logic                      drp_we,
    output logic [DRP_ADDR_WIDTH-1:0] drp_addr,
    output logic [15:0]               drp_di,
    input  logic [15:0]               drp_do,
    input  logic                      drp_rdy
);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } state_t;

    state_t state;

`ifdef APB_DRP_COMPLETER_TIMEOUT_EN
    logic [15:0] wait_cnt;
`endif

    logic unused_wdata_hi;
    assign unused_wdata_hi = ^apb.pwdata[31:16];

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            apb.pready  <= 1'b0;
            apb.pslverr <= 1'b0;
            apb.prdata  <= '0;
            drp_en      <= 1'b0;
            drp_we      <= 1'b0;
            drp_addr    <= '0;
            drp_di      <= '0;
`ifdef APB_DRP_COMPLETER_TIMEOUT_EN
            wait_cnt    <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (apb.psel && apb.penable && !apb.pready) begin
                        if (apb.paddr[0]) begin
                            // misaligned: answer with an error, DRP port untouched
                            apb.pready  <= 1'b1;
                            apb.pslverr <= 1'b1;
                            apb.prdata  <= '0;
                            state       <= RESP;
                        end else begin
                            drp_we   <= apb.pwrite;
                            drp_addr <= apb.paddr[ADDR_WIDTH-1:1];
                            drp_di   <= apb.pwdata[15:0];
                            drp_en   <= 1'b1;
                            state    <= ISSUE;
                        end
                    end
                end
                ISSUE: begin
                    drp_en <= 1'b0;
`ifdef APB_DRP_COMPLETER_TIMEOUT_EN
                    wait_cnt <= '0;
`endif
                    state  <= WAIT;
                end
                WAIT: begin
                    if (drp_rdy) begin
                        apb.prdata  <= drp_we ? 32'h0 : {16'h0, drp_do};
                        apb.pslverr <= 1'b0;
                        apb.pready  <= 1'b1;
                        state       <= RESP;
`ifdef APB_DRP_COMPLETER_TIMEOUT_EN
                    // counter value after this cycle's increment would be TIMEOUT-1,
                    // so pready lands exactly TIMEOUT cycles after drp_en
                    end else if (wait_cnt == 16'(TIMEOUT - 2)) begin
                        apb.prdata  <= '0;
                        apb.pslverr <= 1'b1;
                        apb.pready  <= 1'b1;
                        state       <= RESP;
                    end else begin
                        wait_cnt <= wait_cnt + 16'd1;
`endif
                    end
                end
                RESP: begin
                    apb.pready  <= 1'b0;
                    apb.pslverr <= 1'b0;
                    state       <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_apb_drp_completer.sv
// Directed self-checking bench for apb_drp_completer with a behavioural DRP responder.
module tb_apb_drp_completer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        drp_en;
    logic        drp_we;
    logic [8:0]  drp_addr;
    logic [15:0] drp_di;
    logic [15:0] drp_do  = 16'h0;
    logic        drp_rdy = 1'b0;

    int          rsp_mode  = 1;   // 0 = never answer, 1 = normal, 2 = stray pulse in ISSUE + normal
    int          rsp_delay = 1;
    logic [15:0] rsp_data  = 16'h0;

    int n_checks = 0;
    int n_fail   = 0;
    int en_cnt   = 0;
    int rdy_cnt  = 0;
    logic        last_we   = 1'b0;
    logic [8:0]  last_addr = '0;
    logic [15:0] last_di   = '0;

`ifdef APB_DRP_COMPLETER_TIMEOUT_EN
    localparam int HANG = 10;
`else
    localparam int HANG = 1000;
`endif

    apb_drp_completer_if #(.ADDR_WIDTH(10)) apb ();

    apb_drp_completer #(
        .ADDR_WIDTH(10),
        .DRP_ADDR_WIDTH(9),
        .TIMEOUT(64)
    ) dut (
        .clk(clk),
        .rst(rst),
        .apb(apb),
        .drp_en(drp_en),
        .drp_we(drp_we),
        .drp_addr(drp_addr),
        .drp_di(drp_di),
        .drp_do(drp_do),
        .drp_rdy(drp_rdy)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (drp_en) begin
            en_cnt++;
            last_we   = drp_we;
            last_addr = drp_addr;
            last_di   = drp_di;
        end
        if (apb.pready) rdy_cnt++;
    end

    // drp_rdy lands rsp_delay cycles after the drp_en cycle
    always begin
        @(negedge clk);
        if (drp_en && rsp_mode != 0) begin
            if (rsp_mode == 2) begin
                drp_rdy = 1'b1;
                drp_do  = 16'hDEAD;
            end
            for (int i = 0; i < rsp_delay; i++) begin
                @(negedge clk);
                drp_rdy = 1'b0;
            end
            drp_rdy = 1'b1;
            drp_do  = rsp_data;
            @(negedge clk);
            drp_rdy = 1'b0;
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic apb_xfer(input logic w, input logic [9:0] addr, input logic [31:0] wdata,
                            input bit keep_sel, input int limit,
                            output int lat, output logic [31:0] rdata, output logic err);
        lat   = 0;
        rdata = 'x;
        err   = 1'bx;
        @(negedge clk);
        apb.psel    = 1'b1;
        apb.penable = 1'b0;
        apb.pwrite  = w;
        apb.paddr   = addr;
        apb.pwdata  = wdata;
        @(negedge clk);
        apb.penable = 1'b1;
        for (int i = 1; i <= limit; i++) begin
            @(negedge clk);
            if (apb.pready) begin
                lat   = i;
                rdata = apb.prdata;
                err   = apb.pslverr;
                break;
            end
        end
        if (lat != 0) begin
            apb.penable = 1'b0;
            apb.psel    = keep_sel;
        end
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_pready"},  32'(apb.pready),  32'h0);
        check_eq({tag, "_pslverr"}, 32'(apb.pslverr), 32'h0);
        check_eq({tag, "_prdata"},  apb.prdata,       32'h0);
        check_eq({tag, "_drp_en"},  32'(drp_en),      32'h0);
        check_eq({tag, "_drp_we"},  32'(drp_we),      32'h0);
        check_eq({tag, "_drp_addr"}, 32'(drp_addr),   32'h0);
        check_eq({tag, "_drp_di"},  32'(drp_di),      32'h0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          lat;
        logic [31:0] rd;
        logic        err;
        int          e0, r0;

        apb.psel    = 1'b0;
        apb.penable = 1'b0;
        apb.pwrite  = 1'b0;
        apb.paddr   = '0;
        apb.pwdata  = '0;
        rst         = 1'b1;
        idle(3);
        check_all_zero("reset");
        rst = 1'b0;
        idle(2);

        // write, drp_rdy 3 cycles after drp_en
        rsp_mode = 1; rsp_delay = 3; e0 = en_cnt; r0 = rdy_cnt;
        apb_xfer(1'b1, 10'h0A4, 32'h1234_ABCD, 1'b0, 50, lat, rd, err);
        idle(3);
        check_eq("wr_latency", 32'(lat), 32'd5);
        check_eq("wr_pslverr", 32'(err), 32'h0);
        check_eq("wr_prdata",  rd, 32'h0);
        check_eq("wr_en_count", 32'(en_cnt - e0), 32'd1);
        check_eq("wr_pready_count", 32'(rdy_cnt - r0), 32'd1);
        check_eq("wr_drp_we",   32'(last_we), 32'h1);
        check_eq("wr_drp_addr", 32'(last_addr), 32'h052);
        check_eq("wr_drp_di",   32'(last_di), 32'hABCD);

        // misaligned
        e0 = en_cnt; r0 = rdy_cnt;
        apb_xfer(1'b1, 10'h011, 32'hFFFF_5555, 1'b0, 50, lat, rd, err);
        idle(3);
        check_eq("mis_latency", 32'(lat), 32'd1);
        check_eq("mis_pslverr", 32'(err), 32'h1);
        check_eq("mis_prdata",  rd, 32'h0);
        check_eq("mis_en_count", 32'(en_cnt - e0), 32'd0);
        check_eq("mis_pready_count", 32'(rdy_cnt - r0), 32'd1);

        // read, earliest drp_rdy
        rsp_delay = 1; rsp_data = 16'hBEEF;
        apb_xfer(1'b0, 10'h010, 32'h0, 1'b0, 50, lat, rd, err);
        idle(3);
        check_eq("rd_latency", 32'(lat), 32'd3);
        check_eq("rd_prdata",  rd, 32'h0000_BEEF);
        check_eq("rd_pslverr", 32'(err), 32'h0);
        check_eq("rd_drp_we",  32'(last_we), 32'h0);
        check_eq("rd_drp_addr", 32'(last_addr), 32'h008);

`ifdef APB_DRP_COMPLETER_TIMEOUT_EN
        rsp_mode = 0;
        apb_xfer(1'b0, 10'h040, 32'h0, 1'b0, 200, lat, rd, err);
        idle(3);
        check_eq("to_latency", 32'(lat), 32'd65);
        check_eq("to_pslverr", 32'(err), 32'h1);
        check_eq("to_prdata",  rd, 32'h0);
        rsp_mode = 1;
        apb_xfer(1'b0, 10'h010, 32'h0, 1'b0, 50, lat, rd, err);
        idle(3);
        check_eq("rd2_prdata", rd, 32'h0000_BEEF);
`endif

        // DRP never answers; reset while in WAIT
        rsp_mode = 0; e0 = en_cnt; r0 = rdy_cnt;
        apb_xfer(1'b0, 10'h3FE, 32'hFFFF_C3C3, 1'b0, HANG, lat, rd, err);
        check_eq("hang_no_pready", 32'(lat), 32'd0);
        check_eq("hang_en_count", 32'(en_cnt - e0), 32'd1);
        check_eq("hang_drp_addr", 32'(last_addr), 32'h1FF);
        rst         = 1'b1;
        apb.psel    = 1'b0;
        apb.penable = 1'b0;
        @(negedge clk);
        check_all_zero("rst_wait");
        rst = 1'b0;
        idle(5);
        check_eq("rst_no_pready", 32'(rdy_cnt - r0), 32'd0);
        rsp_mode = 1; rsp_delay = 1; rsp_data = 16'h5A5A;
        apb_xfer(1'b0, 10'h020, 32'h0, 1'b0, 50, lat, rd, err);
        idle(3);
        check_eq("post_rst_prdata", rd, 32'h0000_5A5A);
        check_eq("post_rst_latency", 32'(lat), 32'd3);

        // back-to-back reads, psel held, stray drp_rdy in ISSUE
        rsp_mode = 2; rsp_delay = 2; rsp_data = 16'h1111; e0 = en_cnt; r0 = rdy_cnt;
        apb_xfer(1'b0, 10'h100, 32'h0, 1'b1, 50, lat, rd, err);
        check_eq("b2b0_latency", 32'(lat), 32'd4);
        check_eq("b2b0_prdata",  rd, 32'h0000_1111);
        rsp_data = 16'h2222;
        apb_xfer(1'b0, 10'h102, 32'h0, 1'b0, 50, lat, rd, err);
        check_eq("b2b1_latency", 32'(lat), 32'd4);
        check_eq("b2b1_prdata",  rd, 32'h0000_2222);
        check_eq("b2b1_drp_addr", 32'(last_addr), 32'h081);
        idle(5);
        check_eq("b2b_en_count", 32'(en_cnt - e0), 32'd2);
        check_eq("b2b_pready_count", 32'(rdy_cnt - r0), 32'd2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
